// File: rtl/qpu_exu_alu_dpath_arb_pkg.sv
// Shared constants and types for the EXU ALU datapath arbiter.
// Requester indices, counts and the one-hot to index helper live here.
package qpu_exu_alu_dpath_arb_pkg;

    localparam int QPU_XLEN = 32;
    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;

    typedef enum logic [ID_W-1:0] {
        REQ_ALU = 2'd0,
        REQ_BJP = 2'd1,
        REQ_LSU = 2'd2,
        REQ_QIU = 2'd3
    } req_id_e;

    // Grant vectors are one-hot, so OR-ing the indices of set bits yields the index.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) id = id | ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/qpu_rr_pick4.sv
// Combinational 4-way rotating priority picker: grants the first valid
// requester found scanning upward from ptr_i, wrapping 3 -> 0.
module qpu_rr_pick4
    import qpu_exu_alu_dpath_arb_pkg::*;
(
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr_i + ID_W'(i);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qpu_exu_alu_dpath_arb.sv
// Arbiter/sequencer for the shared EXU ALU datapath: picks one of four
// requesters per cycle and returns the datapath result through a one-entry register.
module qpu_exu_alu_dpath_arb
    import qpu_exu_alu_dpath_arb_pkg::*;
#(
    parameter int XLEN      = QPU_XLEN,
    parameter int PRIO_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  logic             flush,
    output logic [N_REQ-1:0] dpath_sel,
    input  logic [XLEN-1:0]  dpath_res,
    input  logic             dpath_cmp_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [XLEN-1:0]  rsp_res,
    output logic             rsp_cmp
);

    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [XLEN-1:0]  rsp_res_q;
    logic             rsp_cmp_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  pick_ptr;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_id;
    logic             slot_free;
    logic             accept;

    // Fixed priority is the rotating picker anchored at ALU.
    assign pick_ptr = (PRIO_MODE != 0) ? '0 : ptr_q;

    qpu_rr_pick4 u_pick (
        .valid_i (req_valid),
        .ptr_i   (pick_ptr),
        .grant_o (grant)
    );

    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign accept    = rst_n & slot_free & ~flush & (|req_valid);
    assign req_ready = accept ? grant : '0;
    assign dpath_sel = req_ready;
    assign win_id    = onehot_to_id(grant);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_cmp_q   <= 1'b0;
            ptr_q       <= '0;
        end else if (flush) begin
            rsp_valid_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win_id;
            rsp_res_q   <= dpath_res;
            rsp_cmp_q   <= dpath_cmp_res;
            ptr_q       <= win_id + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_cmp   = rsp_cmp_q;

endmodule

// File: tb/tb_qpu_exu_alu_dpath_arb.sv
// Directed bench for qpu_exu_alu_dpath_arb: a round-robin instance driven from a
// vector table, plus hand sequences for fixed priority and async reset.
module tb_qpu_exu_alu_dpath_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic        flush;
    logic [31:0] dpath_res;
    logic        dpath_cmp_res;
    logic        rsp_ready;

    logic [3:0]  r_req_ready, r_dpath_sel;
    logic        r_rsp_valid, r_rsp_cmp;
    logic [1:0]  r_rsp_id;
    logic [31:0] r_rsp_res;

    logic [3:0]  f_req_ready, f_dpath_sel;
    logic        f_rsp_valid, f_rsp_cmp;
    logic [1:0]  f_rsp_id;
    logic [31:0] f_rsp_res;

    int n_checks = 0;
    int n_errors = 0;

    qpu_exu_alu_dpath_arb #(.XLEN(32), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r_req_ready),
        .flush(flush), .dpath_sel(r_dpath_sel), .dpath_res(dpath_res),
        .dpath_cmp_res(dpath_cmp_res), .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(r_rsp_id), .rsp_res(r_rsp_res), .rsp_cmp(r_rsp_cmp)
    );

    qpu_exu_alu_dpath_arb #(.XLEN(32), .PRIO_MODE(1)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(f_req_ready),
        .flush(flush), .dpath_sel(f_dpath_sel), .dpath_res(dpath_res),
        .dpath_cmp_res(dpath_cmp_res), .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(f_rsp_id), .rsp_res(f_rsp_res), .rsp_cmp(f_rsp_cmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  rv;
        logic        fl;
        logic        rr;
        logic [31:0] res;
        logic        cmp;
        logic [3:0]  exp_rdy;
        logic        exp_v;
        logic [1:0]  exp_id;
        logic [31:0] exp_res;
        logic        exp_cmp;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    task automatic drive(input logic [3:0] rv, input logic fl, input logic rr,
                         input logic [31:0] res, input logic cmp);
        req_valid     = rv;
        flush         = fl;
        rsp_ready     = rr;
        dpath_res     = res;
        dpath_cmp_res = cmp;
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase one cycle later.
    task automatic apply_vec(input int i);
        drive(tbl[i].rv, tbl[i].fl, tbl[i].rr, tbl[i].res, tbl[i].cmp);
        #1;
        check($sformatf("v%0d req_ready", i), 32'(r_req_ready), 32'(tbl[i].exp_rdy));
        check($sformatf("v%0d dpath_sel", i), 32'(r_dpath_sel), 32'(tbl[i].exp_rdy));
        @(posedge clk);
        #1;
        check($sformatf("v%0d rsp_valid", i), 32'(r_rsp_valid), 32'(tbl[i].exp_v));
        check($sformatf("v%0d rsp_id", i), 32'(r_rsp_id), 32'(tbl[i].exp_id));
        check($sformatf("v%0d rsp_res", i), r_rsp_res, tbl[i].exp_res);
        check($sformatf("v%0d rsp_cmp", i), 32'(r_rsp_cmp), 32'(tbl[i].exp_cmp));
    endtask

    task automatic do_reset();
        drive(4'b1111, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", 32'(r_rsp_valid), 32'h0);
        check("reset rsp_id", 32'(r_rsp_id), 32'h0);
        check("reset rsp_res", r_rsp_res, 32'h0);
        check("reset rsp_cmp", 32'(r_rsp_cmp), 32'h0);
        check("reset req_ready", 32'(r_req_ready), 32'h0);
        check("reset dpath_sel", 32'(f_dpath_sel), 32'h0);
        drive(4'b0000, 1'b0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              rv       fl    rr    res           cmp   rdy      v     id     res           cmp
        tbl[0]  = '{4'b0100, 1'b0, 1'b1, 32'h0000_1004, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h0000_1004, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h0000_1004, 1'b0};
        tbl[2]  = '{4'b1111, 1'b0, 1'b1, 32'h0000_00A0, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h0000_00A0, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 1'b1, 32'h0000_00A1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h0000_00A1, 1'b0};
        tbl[4]  = '{4'b1111, 1'b0, 1'b1, 32'h0000_00A2, 1'b0, 4'b0010, 1'b1, 2'd1, 32'h0000_00A2, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, 1'b1, 32'h0000_00A3, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h0000_00A3, 1'b0};
        tbl[6]  = '{4'b1111, 1'b0, 1'b1, 32'h0000_00A4, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h0000_00A4, 1'b0};
        tbl[7]  = '{4'b1111, 1'b0, 1'b1, 32'h0000_00A5, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h0000_00A5, 1'b0};
        tbl[8]  = '{4'b0001, 1'b0, 1'b0, 32'h0000_00B0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h0000_00A5, 1'b0};
        tbl[9]  = '{4'b0001, 1'b0, 1'b0, 32'h0000_00B2, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h0000_00A5, 1'b0};
        tbl[10] = '{4'b0001, 1'b0, 1'b1, 32'h0000_00B1, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h0000_00B1, 1'b0};
        tbl[11] = '{4'b1000, 1'b1, 1'b0, 32'h0000_00C0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0000_00B1, 1'b0};
        tbl[12] = '{4'b1001, 1'b0, 1'b0, 32'h0000_00C1, 1'b0, 4'b1000, 1'b1, 2'd3, 32'h0000_00C1, 1'b0};
        tbl[13] = '{4'b0110, 1'b0, 1'b1, 32'h0000_00C2, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h0000_00C2, 1'b1};
        tbl[14] = '{4'b0110, 1'b0, 1'b1, 32'h0000_00C3, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h0000_00C3, 1'b0};
        tbl[15] = '{4'b0000, 1'b0, 1'b1, 32'h0000_00C4, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h0000_00C3, 1'b0};

        do_reset();
        for (int i = 0; i < NV; i++) apply_vec(i);

        // Fixed priority: BJP keeps winning over QIU while it stays valid.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'b1010, 1'b0, 1'b1, 32'h0000_0D00 + 32'(k), 1'b0);
            #1;
            check($sformatf("fix%0d req_ready", k), 32'(f_req_ready), 32'h2);
            @(posedge clk);
            #1;
            check($sformatf("fix%0d rsp_id", k), 32'(f_rsp_id), 32'h1);
            check($sformatf("fix%0d rsp_res", k), f_rsp_res, 32'h0000_0D00 + 32'(k));
        end
        drive(4'b1000, 1'b0, 1'b1, 32'h0000_0E00, 1'b0);
        #1;
        check("fix qiu req_ready", 32'(f_req_ready), 32'h8);
        @(posedge clk);
        #1;
        check("fix qiu rsp_id", 32'(f_rsp_id), 32'h3);
        check("fix qiu rsp_valid", 32'(f_rsp_valid), 32'h1);

        // Async reset while FULL: pointer moves to QIU by an LSU grant, then reset clears it.
        drive(4'b0100, 1'b0, 1'b1, 32'h0000_F00D, 1'b0);
        @(posedge clk);
        #1;
        check("pre-reset rsp_valid", 32'(r_rsp_valid), 32'h1);
        check("pre-reset rsp_res", r_rsp_res, 32'h0000_F00D);
        drive(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst rsp_valid", 32'(r_rsp_valid), 32'h0);
        check("async rst rsp_res", r_rsp_res, 32'h0);
        drive(4'b1111, 1'b0, 1'b1, 32'h0000_0A11, 1'b0);
        #1;
        check("async rst req_ready", 32'(r_req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst req_ready", 32'(r_req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("post-rst rsp_id", 32'(r_rsp_id), 32'h0);
        check("post-rst rsp_res", r_rsp_res, 32'h0000_0A11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
